// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO read port and output stream bundle for fifo_stream_reader
//
// Purpose
//   Groups the two handshake sides of the stream reader: the read port of the
//   sync FIFO being drained and the valid/ready stream handed to the consumer.
//
// Signals
//   fifo_empty      FIFO empty flag                          (FIFO -> reader)
//   fifo_underflow  FIFO underflow flag                      (FIFO -> reader)
//   fifo_data_out   FIFO read data, valid the clk after rd   (FIFO -> reader)
//   fifo_rd_en      read request                             (reader -> FIFO)
//   m_valid         stream beat valid                        (reader -> consumer)
//   m_data          stream beat data                         (reader -> consumer)
//   m_ready         consumer accepts                         (consumer -> reader)
//
// Modports
//   master  the reader's view
//   slave   the environment's view (FIFO plus consumer)

interface fifo_stream_reader_if #(
   parameter int DATA_W = 16
) ();
   logic              fifo_empty;
   logic              fifo_underflow;
   logic [DATA_W-1:0] fifo_data_out;
   logic              fifo_rd_en;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_ready;

   modport master (
      input  fifo_empty,
      input  fifo_underflow,
      input  fifo_data_out,
      output fifo_rd_en,
      output m_valid,
      output m_data,
      input  m_ready
   );

   modport slave (
      output fifo_empty,
      output fifo_underflow,
      output fifo_data_out,
      input  fifo_rd_en,
      input  m_valid,
      input  m_data,
      output m_ready
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - read-side FIFO drain controller with 2-entry stream buffer
//
// Purpose
//   Drains a sync FIFO through fifo_rd_en and absorbs the one-clock read
//   latency of fifo_data_out in a 2-entry output buffer, presenting the data
//   as a valid/ready stream. With m_ready held high it sustains one beat per
//   clock. Delivered beats are counted and any FIFO underflow is latched.
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous active-high reset
//   enable         1 = new reads allowed; 0 = buffered/in-flight data still drains
//   flush          synchronous discard of buffered and in-flight data
//   bus            fifo_stream_reader_if.master (FIFO read port + output stream)
//   beat_cnt       beats delivered since reset, wraps modulo 2^CNT_W
//   err_underflow  sticky, set whenever fifo_underflow is sampled high
//
// Parameters
//   DATA_W  FIFO/stream data width
//   CNT_W   delivered-beat counter width

module fifo_stream_reader #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 flush,
   fifo_stream_reader_if.master bus,
   output logic [CNT_W-1:0]     beat_cnt,
   output logic                 err_underflow
);

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

   occ_t              occ_q;
   occ_t              occ_d;
   logic              inflight_q;
   logic [DATA_W-1:0] entry0_q;
   logic [DATA_W-1:0] entry0_d;
   logic [DATA_W-1:0] entry1_q;
   logic [DATA_W-1:0] entry1_d;

   logic              pop;
   logic              capture;
   logic              rd_en;
   logic [2:0]        credit_used;
   logic [2:0]        credit_limit;

   // A beat leaves whenever the head entry is valid and the consumer takes it.
   assign pop     = (occ_q != OCC_EMPTY) && bus.m_ready;
   // Data requested last clock is on fifo_data_out now.
   assign capture = inflight_q;

   // Credit rule: buffered + in-flight beats, less the one leaving this clock,
   // must stay below the buffer depth of 2, so every capture has a free slot.
   // Written as used < 2 + pop to stay in unsigned arithmetic.
   assign credit_used  = {1'b0, occ_q} + {2'b00, inflight_q};
   assign credit_limit = 3'd2 + {2'b00, pop};

   // Never request on an empty FIFO, so the reader itself cannot underflow it.
   assign rd_en = !rst && enable && !flush && !bus.fifo_empty &&
                  (credit_used < credit_limit);

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = (occ_q != OCC_EMPTY);
   assign bus.m_data     = entry0_q;

   // Occupancy FSM and buffer datapath. Entry0 is always the head; a capture
   // lands at the tail, which depends on whether the head leaves this clock.
   always_comb begin
      occ_d    = occ_q;
      entry0_d = entry0_q;
      entry1_d = entry1_q;

      if (flush) begin
         occ_d = OCC_EMPTY;
      end else begin
         unique case (occ_q)
            OCC_EMPTY: begin
               if (capture) begin
                  occ_d    = OCC_ONE;
                  entry0_d = bus.fifo_data_out;
               end
            end
            OCC_ONE: begin
               unique case ({capture, pop})
                  2'b10: begin
                     occ_d    = OCC_TWO;
                     entry1_d = bus.fifo_data_out;
                  end
                  2'b01: begin
                     occ_d = OCC_EMPTY;
                  end
                  2'b11: begin
                     // Head leaves and the new beat becomes the head.
                     entry0_d = bus.fifo_data_out;
                  end
                  default: begin
                  end
               endcase
            end
            OCC_TWO: begin
               if (pop) begin
                  entry0_d = entry1_q;
                  if (capture) begin
                     // Unreachable under the credit rule; kept order-safe anyway.
                     entry1_d = bus.fifo_data_out;
                  end else begin
                     occ_d = OCC_ONE;
                  end
               end
            end
            default: begin
               occ_d = OCC_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q         <= OCC_EMPTY;
         inflight_q    <= 1'b0;
         entry0_q      <= '0;
         entry1_q      <= '0;
         beat_cnt      <= '0;
         err_underflow <= 1'b0;
      end else begin
         occ_q      <= occ_d;
         // rd_en is already forced low during flush, so this also clears
         // the in-flight marker on a flush edge.
         inflight_q <= rd_en;
         entry0_q   <= entry0_d;
         entry1_q   <= entry1_d;
         // A beat taken on the flush clock is discarded, not delivered.
         if (pop && !flush) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
         if (bus.fifo_underflow) begin
            err_underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        flush;
   logic [15:0] beat_cnt;
   logic        err_underflow;

   logic        enable_w;
   logic [3:0]  beat_cnt_w;
   logic        err_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_stream_reader_if #(.DATA_W(16)) bus ();
   fifo_stream_reader_if #(.DATA_W(16)) bus_w ();

   fifo_stream_reader #(.DATA_W(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush),
      .bus(bus), .beat_cnt(beat_cnt), .err_underflow(err_underflow)
   );

   fifo_stream_reader #(.DATA_W(16), .CNT_W(4)) dut_w (
      .clk(clk), .rst(rst), .enable(enable_w), .flush(1'b0),
      .bus(bus_w), .beat_cnt(beat_cnt_w), .err_underflow(err_w)
   );

   // Behavioural sync FIFO for the main DUT: writes become visible one clock
   // after they are requested, reads return data the clock after rd_en.
   logic [15:0] fq[$];
   logic [15:0] push_q[$];
   logic        fifo_empty_r = 1'b1;
   logic [15:0] fdout_r = 16'h0;
   int          cyc = 0;

   assign bus.fifo_empty    = fifo_empty_r;
   assign bus.fifo_data_out = fdout_r;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.fifo_rd_en && fq.size() > 0) fdout_r <= fq.pop_front();
      while (push_q.size() > 0) fq.push_back(push_q.pop_front());
      fifo_empty_r <= (fq.size() == 0);
   end

   // Endless counting source for the narrow-counter DUT: beat k carries value k.
   logic [15:0] wdout_r = 16'h0;
   assign bus_w.fifo_empty     = 1'b0;
   assign bus_w.fifo_underflow = 1'b0;
   assign bus_w.fifo_data_out  = wdout_r;
   always @(posedge clk) if (bus_w.fifo_rd_en) wdout_r <= wdout_r + 16'd1;

   // Observation at the falling edge: what the next rising edge will act on.
   logic [15:0] got[$];
   int          got_cyc[$];
   int          rd_cyc[$];
   int          empty_viol = 0;
   int          outstanding = 0;
   int          max_out = 0;
   int          first_valid = -1;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.fifo_rd_en) rd_cyc.push_back(cyc);
         if (bus.fifo_rd_en && bus.fifo_empty) empty_viol++;
         if (bus.m_valid && first_valid < 0) first_valid = cyc;
         if (bus.m_valid && bus.m_ready && !flush) begin
            got.push_back(bus.m_data);
            got_cyc.push_back(cyc);
         end
         // Beats read from the FIFO but not yet delivered can never exceed 2.
         if (flush) outstanding = 0;
         else outstanding += int'(bus.fifo_rd_en) - int'(bus.m_valid && bus.m_ready);
         if (outstanding > max_out) max_out = outstanding;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_obs();
      got.delete(); got_cyc.delete(); rd_cyc.delete();
      empty_viol = 0; outstanding = 0; max_out = 0; first_valid = -1;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; flush = 1'b0;
      bus.m_ready = 1'b0; bus.fifo_underflow = 1'b0;
      fq.delete(); push_q.delete();
      tick(2);
      clear_obs();
      rst = 1'b0;
      tick(1);
   endtask

   task automatic push_seq(input logic [15:0] first, input int n);
      for (int i = 0; i < n; i++) push_q.push_back(first + 16'(i));
   endtask

   task automatic wait_got(input int n, input int budget, input string name);
      for (int c = 0; c < budget && got.size() < n; c++) tick(1);
      checks++;
      if (got.size() < n) begin
         errors++;
         $display("FAIL %s_timeout: got %0d beats, required %0d", name, got.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; flush = 1'b0;
      bus.m_ready = 1'b1; bus.fifo_underflow = 1'b0;
      enable_w = 1'b0; bus_w.m_ready = 1'b0;
      push_seq(16'h00AA, 3);
      tick(3);
      checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b required 0", bus.fifo_rd_en); end
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b required 0", bus.m_valid); end
      checks++; if (bus.m_data !== 16'h0) begin errors++; $display("FAIL rst_m_data: got %h required 0000", bus.m_data); end
      checks++; if (beat_cnt !== 16'h0) begin errors++; $display("FAIL rst_beat_cnt: got %0d required 0", beat_cnt); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", err_underflow); end
   endtask

   task automatic test_stream();
      do_reset();
      push_seq(16'h0001, 8);
      tick(1);
      enable = 1'b1; bus.m_ready = 1'b1;
      wait_got(8, 40, "stream");
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== 16'(i + 1) || got_cyc[i] !== got_cyc[0] + i) begin
            errors++;
            $display("FAIL stream_beat%0d: got %h at +%0d required %h at +%0d",
                     i, got[i], got_cyc[i] - got_cyc[0], 16'(i + 1), i);
         end
      end
      checks++;
      if (rd_cyc.size() == 0 || first_valid - rd_cyc[0] != 2) begin
         errors++;
         $display("FAIL stream_latency: got first_valid %0d first_rd %0d required gap 2",
                  first_valid, rd_cyc.size() > 0 ? rd_cyc[0] : -1);
      end
      checks++; if (beat_cnt !== 16'd8) begin errors++; $display("FAIL stream_beat_cnt: got %0d required 8", beat_cnt); end
      tick(3);
      checks++; if (empty_viol != 0) begin errors++; $display("FAIL stream_rd_on_empty: got %0d required 0", empty_viol); end
   endtask

   task automatic test_backpressure();
      do_reset();
      push_seq(16'h0001, 4);
      tick(1);
      enable = 1'b1; bus.m_ready = 1'b0;
      tick(10);
      checks++; if (rd_cyc.size() != 2) begin errors++; $display("FAIL bp_rd_pulses: got %0d required 2", rd_cyc.size()); end
      checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 16'h0001) begin errors++; $display("FAIL bp_head: got %b/%h required 1/0001", bus.m_valid, bus.m_data); end
      checks++; if (fq.size() != 2) begin errors++; $display("FAIL bp_fifo_left: got %0d required 2", fq.size()); end
      tick(3);
      checks++; if (bus.m_data !== 16'h0001) begin errors++; $display("FAIL bp_stable: got %h required 0001", bus.m_data); end
      bus.m_ready = 1'b1;
      wait_got(4, 30, "bp");
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== 16'(i + 1) || (i > 0 && got_cyc[i] - got_cyc[i-1] > 2)) begin
            errors++;
            $display("FAIL bp_beat%0d: got %h required %h within 1 idle clk", i, got[i], 16'(i + 1));
         end
      end
   endtask

   task automatic test_random();
      int pushed = 0;
      int bad = 0;
      do_reset();
      enable = 1'b1;
      for (int c = 0; c < 3000 && got.size() < 100; c++) begin
         if (pushed < 100 && $urandom_range(1, 0) == 1) begin
            push_q.push_back(16'(pushed));
            pushed++;
         end
         bus.m_ready = ($urandom_range(1, 0) == 1);
         tick(1);
      end
      bus.m_ready = 1'b0;
      tick(1);
      checks++; if (got.size() != 100) begin errors++; $display("FAIL rand_count: got %0d required 100", got.size()); end
      for (int i = 0; i < got.size() && i < 100; i++) if (got[i] !== 16'(i)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rand_order: got %0d misordered beats required 0", bad); end
      checks++; if (beat_cnt !== 16'd100) begin errors++; $display("FAIL rand_beat_cnt: got %0d required 100", beat_cnt); end
      checks++; if (max_out > 2) begin errors++; $display("FAIL rand_occupancy: got %0d required <=2", max_out); end
      checks++; if (empty_viol != 0) begin errors++; $display("FAIL rand_rd_on_empty: got %0d required 0", empty_viol); end
   endtask

   task automatic test_flush();
      logic [15:0] exp_next;
      logic [15:0] bc_before;
      int          n_before;
      int          rem;
      do_reset();
      push_seq(16'h0010, 6);
      tick(1);
      enable = 1'b1; bus.m_ready = 1'b0;
      tick(6);
      checks++; if (bus.m_valid !== 1'b1 || fq.size() != 4) begin errors++; $display("FAIL flush_full: got valid %b fifo %0d required 1/4", bus.m_valid, fq.size()); end
      flush = 1'b1;
      exp_next = fq[0];
      tick(1);
      flush = 1'b0;
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b required 0", bus.m_valid); end
      checks++; if (beat_cnt !== 16'd0) begin errors++; $display("FAIL flush_cnt_idle: got %0d required 0", beat_cnt); end
      bus.m_ready = 1'b1;
      wait_got(4, 30, "flush_resume");
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_next + 16'(i)) begin errors++; $display("FAIL flush_resume%0d: got %h required %h", i, got[i], exp_next + 16'(i)); end
      end
      // Flush while streaming so a read is in flight and a pop coincides.
      push_seq(16'h0100, 20);
      tick(1);
      tick(5);
      flush = 1'b1;
      exp_next  = fq[0];
      bc_before = beat_cnt;
      n_before  = got.size();
      tick(1);
      flush = 1'b0;
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL flush_stream_valid: got %b required 0", bus.m_valid); end
      checks++; if (beat_cnt !== bc_before) begin errors++; $display("FAIL flush_stream_cnt: got %0d required %0d", beat_cnt, bc_before); end
      rem = 16'h0113 - int'(exp_next) + 1;
      wait_got(n_before + rem, 60, "flush_stream");
      checks++;
      if (got.size() <= n_before || got[n_before] !== exp_next || got[got.size()-1] !== 16'h0113) begin
         errors++;
         $display("FAIL flush_stream_next: got %h..%h required %h..0113",
                  got.size() > n_before ? got[n_before] : 16'hxxxx, got.size() > 0 ? got[got.size()-1] : 16'hxxxx, exp_next);
      end
      checks++; if (beat_cnt !== 16'(got.size())) begin errors++; $display("FAIL flush_total_cnt: got %0d required %0d", beat_cnt, got.size()); end
   endtask

   task automatic test_underflow_reset();
      do_reset();
      push_seq(16'h0021, 2);
      tick(1);
      enable = 1'b1; bus.m_ready = 1'b1;
      wait_got(2, 20, "uf_pre");
      bus.m_ready = 1'b0;
      push_seq(16'h0031, 3);
      tick(6);
      bus.fifo_underflow = 1'b1;
      tick(1);
      bus.fifo_underflow = 1'b0;
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b required 1", err_underflow); end
      tick(5);
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b required 1", err_underflow); end
      checks++; if (beat_cnt !== 16'd2 || bus.m_valid !== 1'b1) begin errors++; $display("FAIL uf_state: got cnt %0d valid %b required 2/1", beat_cnt, bus.m_valid); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b required 0", bus.m_valid); end
      checks++; if (bus.m_data !== 16'h0) begin errors++; $display("FAIL arst_data: got %h required 0000", bus.m_data); end
      checks++; if (beat_cnt !== 16'h0) begin errors++; $display("FAIL arst_cnt: got %0d required 0", beat_cnt); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL arst_err: got %b required 0", err_underflow); end
      do_reset();
   endtask

   task automatic test_wrap();
      int n = 0;
      int bad = 0;
      bit chk16 = 1'b0;
      do_reset();
      enable_w = 1'b1; bus_w.m_ready = 1'b1;
      for (int c = 0; c < 100 && n < 17; c++) begin
         @(negedge clk);
         if (bus_w.m_valid && bus_w.m_ready) begin
            n++;
            if (bus_w.m_data !== 16'(n)) bad++;
         end
         @(posedge clk);
         #1;
         if (n == 16 && !chk16) begin
            chk16 = 1'b1;
            checks++;
            if (beat_cnt_w !== 4'd0) begin errors++; $display("FAIL wrap16: got %0d required 0", beat_cnt_w); end
         end
         if (n == 17) bus_w.m_ready = 1'b0;
      end
      enable_w = 1'b0;
      checks++; if (n != 17) begin errors++; $display("FAIL wrap_timeout: got %0d beats required 17", n); end
      checks++; if (beat_cnt_w !== 4'd1) begin errors++; $display("FAIL wrap17: got %0d required 1", beat_cnt_w); end
      checks++; if (bad != 0) begin errors++; $display("FAIL wrap_order: got %0d misordered required 0", bad); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_random();
      test_flush();
      test_underflow_reset();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
